reaction_timer_multi: RTL and testbench

Parametrised multi-player reaction timer. Generates a pseudo-random delay, asserts a stimulus, then measures in milliseconds (packed BCD) how long the first of N players takes to press stop. Detects false starts and timeouts, and tracks the best valid time since reset. Sits between debounced button inputs and the seven-segment display driver.

---
 rtl/reaction_timer_multi.sv | 247 ++++++++++++++++++++++++
 tb/tb_reaction_timer_multi.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer_multi.sv
// Multi-player reaction timer: random arm delay, millisecond reaction measurement in
// packed BCD, false-start and timeout detection, and best valid time since reset.
module reaction_timer_multi #(
  parameter  int TICK_DVSR   = 100000,
  parameter  int N_PLAYERS   = 2,
  parameter  int DIGITS      = 4,
  parameter  int MIN_DELAY_S = 2,
  parameter  int MAX_DELAY_S = 15,
  parameter  int TIMEOUT_MS  = 1000,
  localparam int W           = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [N_PLAYERS-1:0]  i_stop,
  output logic                  o_stimulus,
  output logic [4*DIGITS-1:0]   o_time,
  output logic [4*DIGITS-1:0]   o_best,
  output logic [W-1:0]          o_winner,
  output logic                  o_false_start,
  output logic                  o_timeout,
  output logic                  o_done
);

  localparam int BW    = 4 * DIGITS;
  localparam int PW    = (TICK_DVSR > 1) ? $clog2(TICK_DVSR) : 1;
  localparam int SW    = 16;
  localparam int RANGE = MAX_DELAY_S - MIN_DELAY_S + 1;

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DVSR - 1);
  localparam logic [BW-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_REACT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [BW-1:0] to_bcd(input int n);
    logic [BW-1:0] r;
    int            t;
    r = '0;
    t = n;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Ripple BCD increment: a digit advances only while every lower digit wraps 9 -> 0.
  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (c && (v[4*k +: 4] == 4'd9)) begin
        r[4*k +: 4] = 4'd0;
      end else if (c) begin
        r[4*k +: 4] = v[4*k +: 4] + 4'd1;
        c           = 1'b0;
      end else begin
        r[4*k +: 4] = v[4*k +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] lowest_set(input logic [N_PLAYERS-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic logic [SW-1:0] arm_delay(input logic [7:0] rnd);
    return SW'(MIN_DELAY_S + (int'(rnd) % RANGE));
  endfunction

  localparam logic [BW-1:0] TIMEOUT_BCD = to_bcd(TIMEOUT_MS);

  state_t          r_state;
  state_t          w_next;
  logic            r_start_q;
  logic [15:0]     r_lfsr;
  logic [PW-1:0]   r_presc;
  logic [PW-1:0]   w_presc;
  logic [9:0]      r_ms;
  logic [9:0]      w_ms;
  logic [SW-1:0]   r_secs;
  logic [SW-1:0]   w_secs;
  logic [BW-1:0]   r_time;
  logic [BW-1:0]   w_time;
  logic [BW-1:0]   r_best;
  logic [BW-1:0]   w_best;
  logic [W-1:0]    r_winner;
  logic [W-1:0]    w_winner;
  logic            r_false_start;
  logic            w_false_start;
  logic            r_timeout;
  logic            w_timeout;
  logic            r_stimulus;
  logic            r_done;
  logic            w_start_edge;
  logic            w_tick;
  logic            w_sec_tick;
  logic            w_any_stop;
  logic            w_lfsr_fb;

  assign w_start_edge = i_start & ~r_start_q;
  assign w_tick       = (r_presc == TICK_LAST);
  assign w_sec_tick   = w_tick & (r_ms == 10'd999);
  assign w_any_stop   = |i_stop;
  assign w_lfsr_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Next-state and next-result logic for the round sequencer.
  always_comb begin
    w_next        = r_state;
    w_presc       = w_tick ? '0 : r_presc + PW'(1);
    w_ms          = r_ms;
    w_secs        = r_secs;
    w_time        = r_time;
    w_best        = r_best;
    w_winner      = r_winner;
    w_false_start = r_false_start;
    w_timeout     = r_timeout;
    case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_next        = S_ARM;
          w_secs        = arm_delay(r_lfsr[7:0]);
          w_presc       = '0;
          w_ms          = '0;
          w_time        = '0;
          w_winner      = '0;
          w_false_start = 1'b0;
          w_timeout     = 1'b0;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ARM: begin
        if (w_sec_tick) begin
          w_ms = '0;
        end else if (w_tick) begin
          w_ms = r_ms + 10'd1;
        end else begin
          w_ms = r_ms;
        end
        // A stop during the arm delay is a false start even if the delay expires now.
        if (w_any_stop) begin
          w_next        = S_DONE;
          w_winner      = lowest_set(i_stop);
          w_false_start = 1'b1;
          w_time        = ALL_NINES;
        end else if ((r_secs == '0) || (w_sec_tick && (r_secs == SW'(1)))) begin
          w_next  = S_REACT;
          w_time  = '0;
          w_presc = '0;
          w_secs  = '0;
        end else if (w_sec_tick) begin
          w_secs = r_secs - SW'(1);
        end else begin
          w_secs = r_secs;
        end
      end
      S_REACT: begin
        if (w_any_stop) begin
          w_next   = S_DONE;
          w_winner = lowest_set(i_stop);
          if (r_best > r_time) begin
            w_best = r_time;
          end else begin
            w_best = r_best;
          end
        end else if (r_time == TIMEOUT_BCD) begin
          w_next    = S_DONE;
          w_timeout = 1'b1;
        end else if (w_tick) begin
          w_time = bcd_inc(r_time);
        end else begin
          w_time = r_time;
        end
      end
      S_DONE: begin
        if (w_start_edge) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_DONE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State, LFSR, timing counters and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_start_q     <= 1'b0;
      r_lfsr        <= 16'hACE1;
      r_presc       <= '0;
      r_ms          <= '0;
      r_secs        <= '0;
      r_time        <= '0;
      r_best        <= ALL_NINES;
      r_winner      <= '0;
      r_false_start <= 1'b0;
      r_timeout     <= 1'b0;
      r_stimulus    <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_start_q     <= i_start;
      r_lfsr        <= {r_lfsr[14:0], w_lfsr_fb};
      r_presc       <= w_presc;
      r_ms          <= w_ms;
      r_secs        <= w_secs;
      r_time        <= w_time;
      r_best        <= w_best;
      r_winner      <= w_winner;
      r_false_start <= w_false_start;
      r_timeout     <= w_timeout;
      r_stimulus    <= (w_next == S_REACT);
      r_done        <= (w_next == S_DONE);
    end
  end

  assign o_stimulus    = r_stimulus;
  assign o_time        = r_time;
  assign o_best        = r_best;
  assign o_winner      = r_winner;
  assign o_false_start = r_false_start;
  assign o_timeout     = r_timeout;
  assign o_done        = r_done;

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Bench for reaction_timer_multi: cycle-count behavioural model compared every cycle,
// plus directed rounds with hand-computed literal expectations.
module tb_reaction_timer_multi;

  localparam int TICK  = 4;
  localparam int NP    = 2;
  localparam int DIG   = 4;
  localparam int MIN_S = 1;
  localparam int MAX_S = 2;
  localparam int TO_MS = 50;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  stop  = 2'b00;
  logic        stim;
  logic [15:0] tm;
  logic [15:0] best;
  logic [0:0]  win;
  logic        fs;
  logic        to;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  reaction_timer_multi #(
    .TICK_DVSR  (TICK),
    .N_PLAYERS  (NP),
    .DIGITS     (DIG),
    .MIN_DELAY_S(MIN_S),
    .MAX_DELAY_S(MAX_S),
    .TIMEOUT_MS (TO_MS)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_start      (start),
    .i_stop       (stop),
    .o_stimulus   (stim),
    .o_time       (tm),
    .o_best       (best),
    .o_winner     (win),
    .o_false_start(fs),
    .o_timeout    (to),
    .o_done       (done)
  );

  always #5 clk = ~clk;

  // Model: phase 0 waiting, 1 arming, 2 reacting, 3 finished; times kept as integer ms.
  int          m_phase;
  logic [15:0] m_lfsr;
  logic        m_prev_start;
  int          m_arm_left;
  int          m_react_cyc;
  int          m_time;
  int          m_best;
  int          m_winner;
  logic        m_fs;
  logic        m_to;

  function automatic logic [15:0] ms_to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int first_set(input logic [1:0] s);
    return s[0] ? 0 : 1;
  endfunction

  task automatic model_reset();
    m_phase      = 0;
    m_lfsr       = 16'hACE1;
    m_prev_start = 1'b0;
    m_arm_left   = 0;
    m_react_cyc  = 0;
    m_time       = 0;
    m_best       = 9999;
    m_winner     = 0;
    m_fs         = 1'b0;
    m_to         = 1'b0;
  endtask

  task automatic model_step();
    logic st_edge;
    st_edge = start && !m_prev_start;
    case (m_phase)
      0: if (st_edge) begin
        m_phase    = 1;
        m_arm_left = (MIN_S + int'(m_lfsr[7:0]) % (MAX_S - MIN_S + 1)) * 1000 * TICK;
        m_time     = 0;
        m_fs       = 1'b0;
        m_to       = 1'b0;
        m_winner   = 0;
      end
      1: if (stop != 2'b00) begin
        m_winner = first_set(stop);
        m_fs     = 1'b1;
        m_time   = 9999;
        m_phase  = 3;
      end else begin
        m_arm_left = m_arm_left - 1;
        if (m_arm_left == 0) begin
          m_phase     = 2;
          m_react_cyc = 0;
          m_time      = 0;
        end
      end
      2: if (stop != 2'b00) begin
        m_winner = first_set(stop);
        if (m_time < m_best) m_best = m_time;
        m_phase = 3;
      end else if (m_time == TO_MS) begin
        m_to    = 1'b1;
        m_phase = 3;
      end else begin
        m_react_cyc = m_react_cyc + 1;
        m_time      = m_react_cyc / TICK;
      end
      default: if (st_edge) m_phase = 0;
    endcase
    m_prev_start = start;
    m_lfsr       = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      n_tests++;
      if (stim !== (m_phase == 2) || done !== (m_phase == 3) || tm !== ms_to_bcd(m_time) ||
          best !== ms_to_bcd(m_best) || win !== 1'(m_winner) || fs !== m_fs || to !== m_to) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: got stim=%b done=%b time=%h best=%h win=%0d fs=%b to=%b; want stim=%b done=%b time=%h best=%h win=%0d fs=%b to=%b",
                 $time, stim, done, tm, best, win, fs, to, (m_phase == 2), (m_phase == 3),
                 ms_to_bcd(m_time), ms_to_bcd(m_best), m_winner, m_fs, m_to);
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic press();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
  endtask

  // elapsed = cycles already spent since the start edge was sampled.
  task automatic wait_stim(input int elapsed);
    int cnt;
    cnt = 0;
    while (!stim && cnt < 9000) begin
      cyc(1);
      cnt++;
    end
    n_tests++;
    if (!((cnt + elapsed) == 4000 || (cnt + elapsed) == 8000)) begin
      n_fail++;
      $display("FAIL arm_delay: got %0d cycles, want 4000 or 8000", cnt + elapsed);
    end
  endtask

  task automatic wait_time(input logic [15:0] want);
    int cnt;
    cnt = 0;
    while (tm !== want && cnt < 400) begin
      cyc(1);
      cnt++;
    end
    n_tests++;
    if (tm !== want) begin
      n_fail++;
      $display("FAIL wait_time: got %h, want %h within 400 cycles", tm, want);
    end
  endtask

  initial begin
    int cnt;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    check("reset_best", best, 16'h9999);
    check("reset_time", tm, 16'h0000);
    check("reset_flags", {12'h000, stim, fs, to, done}, 16'h0000);
    check("reset_winner", {15'h0000, win}, 16'h0000);

    // Valid reaction at 23 ms by player 1.
    press();
    wait_stim(1);
    wait_time(16'h0023);
    stop = 2'b10;
    cyc(1);
    check("valid_time", tm, 16'h0023);
    check("valid_winner", {15'h0000, win}, 16'h0001);
    check("valid_done", {15'h0000, done}, 16'h0001);
    check("valid_best", best, 16'h0023);
    stop = 2'b00;

    // First start edge from DONE only returns to IDLE with results held.
    press();
    check("idle_done_low", {15'h0000, done}, 16'h0000);
    check("idle_time_held", tm, 16'h0023);
    press();
    wait_stim(1);
    wait_time(16'h0030);
    stop = 2'b01;
    cyc(1);
    check("slow_time", tm, 16'h0030);
    check("slow_best_kept", best, 16'h0023);
    stop = 2'b00;

    // False start during ARM.
    press();
    press();
    cyc(100);
    stop = 2'b01;
    cyc(1);
    check("fs_flag", {15'h0000, fs}, 16'h0001);
    check("fs_time", tm, 16'h9999);
    check("fs_winner", {15'h0000, win}, 16'h0000);
    check("fs_stim", {15'h0000, stim}, 16'h0000);
    check("fs_best", best, 16'h0023);
    stop = 2'b00;

    // Simultaneous stops: lowest index wins.
    press();
    press();
    wait_stim(1);
    wait_time(16'h0005);
    stop = 2'b11;
    cyc(1);
    check("sim_winner", {15'h0000, win}, 16'h0000);
    check("sim_time", tm, 16'h0005);
    check("sim_best", best, 16'h0005);
    stop = 2'b00;

    // Timeout: 200 cycles to reach 50 ms, one more to detect it.
    press();
    press();
    wait_stim(1);
    cnt = 0;
    while (!done && cnt < 400) begin
      cyc(1);
      cnt++;
    end
    check("to_cycles", 16'(cnt), 16'd201);
    check("to_flag", {15'h0000, to}, 16'h0001);
    check("to_time", tm, 16'h0050);
    check("to_best", best, 16'h0005);

    // Stop on the same cycle the timeout would fire: stop wins.
    press();
    press();
    wait_stim(1);
    wait_time(16'h0050);
    stop = 2'b10;
    cyc(1);
    check("stop_vs_to_flag", {15'h0000, to}, 16'h0000);
    check("stop_vs_to_done", {15'h0000, done}, 16'h0001);
    check("stop_vs_to_winner", {15'h0000, win}, 16'h0001);
    stop = 2'b00;

    // Asynchronous reset mid-REACT.
    press();
    press();
    wait_stim(1);
    cyc(10);
    rst = 1'b1;
    #1;
    check("rst_stim", {15'h0000, stim}, 16'h0000);
    check("rst_best", best, 16'h9999);
    check("rst_time", tm, 16'h0000);
    cyc(1);
    rst = 1'b0;
    cyc(1);

    // Held i_start through DONE must not begin another round.
    start = 1'b1;
    cyc(1);
    wait_stim(0);
    wait_time(16'h0007);
    stop = 2'b01;
    cyc(1);
    stop = 2'b00;
    cyc(20);
    check("held_done", {15'h0000, done}, 16'h0001);
    check("held_time", tm, 16'h0007);
    start = 1'b0;
    cyc(1);
    start = 1'b1;
    cyc(1);
    check("repress_idle", {15'h0000, done}, 16'h0000);
    start = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
